// File: rtl/frame_draw_engine.sv
// frame_draw_engine: rasterises one frame (optional clear, paddle, ball, brick grid)
// into a pixel plot port with ready/valid back-pressure, clipping and disabled-brick skipping.
module frame_draw_engine #(
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter int unsigned COORD_W   = 8,
    parameter int unsigned COLOR_W   = 3,
    parameter int unsigned GRID_COLS = 10,
    parameter int unsigned GRID_ROWS = 2,
    parameter int unsigned GRID_X0   = 35,
    parameter int unsigned GRID_Y0   = 20,
    parameter int unsigned BRICK_W   = 6,
    parameter int unsigned BRICK_H   = 6,
    parameter int unsigned PITCH_X   = 10,
    parameter int unsigned PITCH_Y   = 10,
    parameter int unsigned PADDLE_W  = 16,
    parameter int unsigned PADDLE_H  = 2,
    parameter int unsigned BALL_SZ   = 2,
    parameter int unsigned BG_COLOR  = 0,
    parameter int unsigned FG_COLOR  = 7
) (
    input  logic                           CLOCK,
    input  logic                           RESET,
    input  logic                           START,
    input  logic                           clear_en,
    input  logic [COORD_W-1:0]             paddle_x,
    input  logic [COORD_W-1:0]             paddle_y,
    input  logic [COORD_W-1:0]             ball_x,
    input  logic [COORD_W-1:0]             ball_y,
    input  logic [GRID_COLS*GRID_ROWS-1:0] Brick_enable,
    input  logic [GRID_ROWS*COLOR_W-1:0]   brick_color,
    input  logic                           plot_ready,
    output logic [COORD_W-1:0]             x_draw,
    output logic [COORD_W-1:0]             y_draw,
    output logic [COLOR_W-1:0]             color,
    output logic                           enable_plot,
    output logic                           busy,
    output logic                           complete
);

    localparam int unsigned NB  = GRID_COLS * GRID_ROWS;
    localparam int unsigned OW  = COORD_W + 1;
    localparam int unsigned IW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CLW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int unsigned RW  = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_PADDLE, S_BALL, S_BRICK, S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [OW-1:0]                  dx_q, dx_d, dy_q, dy_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [CLW-1:0]                 col_q, col_d;
    logic [RW-1:0]                  row_q, row_d;
    logic                           clr_q;
    logic [COORD_W-1:0]             pad_x_q, pad_y_q, ball_x_q, ball_y_q;
    logic [NB-1:0]                  en_q;
    logic [GRID_ROWS*COLOR_W-1:0]   bcol_q;

    logic                           accept;
    logic [OW-1:0]                  org_x, org_y, obj_w, obj_h, sum_x, sum_y;
    logic [COLOR_W-1:0]             obj_col, row_col;
    logic                           drawing, skip, vis, step, last_x, last_px;

    assign accept = (state_q == S_IDLE) && START;

    // State, raster counters and the per-frame input snapshot
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            dx_q     <= '0;
            dy_q     <= '0;
            idx_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            clr_q    <= 1'b0;
            pad_x_q  <= '0;
            pad_y_q  <= '0;
            ball_x_q <= '0;
            ball_y_q <= '0;
            en_q     <= '0;
            bcol_q   <= '0;
        end else begin
            state_q <= state_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (accept) begin
                clr_q    <= clear_en;
                pad_x_q  <= paddle_x;
                pad_y_q  <= paddle_y;
                ball_x_q <= ball_x;
                ball_y_q <= ball_y;
                en_q     <= Brick_enable;
                bcol_q   <= brick_color;
            end
        end
    end

    // Current object geometry/colour and the pixel presented this cycle
    always_comb begin
        org_x   = '0;
        org_y   = '0;
        obj_w   = OW'(1);
        obj_h   = OW'(1);
        obj_col = '0;
        drawing = 1'b0;
        skip    = 1'b0;
        row_col = '0;
        for (int unsigned r = 0; r < GRID_ROWS; r++) begin
            if (row_q == RW'(r)) row_col = bcol_q[r*COLOR_W +: COLOR_W];
        end
        case (state_q)
            S_CLEAR: begin
                obj_w   = OW'(SCREEN_W);
                obj_h   = OW'(SCREEN_H);
                obj_col = COLOR_W'(BG_COLOR);
                drawing = 1'b1;
            end
            S_PADDLE: begin
                org_x   = OW'(pad_x_q);
                org_y   = OW'(pad_y_q);
                obj_w   = OW'(PADDLE_W);
                obj_h   = OW'(PADDLE_H);
                obj_col = COLOR_W'(FG_COLOR);
                drawing = 1'b1;
            end
            S_BALL: begin
                org_x   = OW'(ball_x_q);
                org_y   = OW'(ball_y_q);
                obj_w   = OW'(BALL_SZ);
                obj_h   = OW'(BALL_SZ);
                obj_col = COLOR_W'(FG_COLOR);
                drawing = 1'b1;
            end
            S_BRICK: begin
                org_x   = OW'(GRID_X0 + 32'(col_q) * PITCH_X);
                org_y   = OW'(GRID_Y0 + 32'(row_q) * PITCH_Y);
                obj_w   = OW'(BRICK_W);
                obj_h   = OW'(BRICK_H);
                obj_col = row_col;
                drawing = en_q[idx_q];
                skip    = !en_q[idx_q];
            end
            default: ;
        endcase
        // Sums carry one extra bit so far-right/bottom origins clip instead of wrapping
        sum_x       = org_x + dx_q;
        sum_y       = org_y + dy_q;
        vis         = (sum_x < OW'(SCREEN_W)) && (sum_y < OW'(SCREEN_H));
        enable_plot = drawing && vis;
        x_draw      = sum_x[COORD_W-1:0];
        y_draw      = sum_y[COORD_W-1:0];
        color       = obj_col;
        busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        complete    = (state_q == S_DONE);
        step        = drawing && (!vis || plot_ready);
        last_x      = (dx_q == obj_w - OW'(1));
        last_px     = last_x && (dy_q == obj_h - OW'(1));
    end

    // Next-state: raster advance, object sequencing and brick walk
    always_comb begin
        state_d = state_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        idx_d   = idx_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: if (START) state_d = clear_en ? S_CLEAR : S_PADDLE;
            S_DONE: state_d = S_IDLE;
            default: begin
                if (skip || (step && last_px)) begin
                    dx_d = '0;
                    dy_d = '0;
                    case (state_q)
                        S_CLEAR:  state_d = S_PADDLE;
                        S_PADDLE: state_d = S_BALL;
                        S_BALL:   state_d = S_BRICK;
                        default: begin
                            if (idx_q == IW'(NB - 1)) begin
                                state_d = S_DONE;
                                idx_d   = '0;
                                col_d   = '0;
                                row_d   = '0;
                            end else begin
                                idx_d = idx_q + IW'(1);
                                if (col_q == CLW'(GRID_COLS - 1)) begin
                                    col_d = '0;
                                    row_d = row_q + RW'(1);
                                end else begin
                                    col_d = col_q + CLW'(1);
                                end
                            end
                        end
                    endcase
                end else if (step) begin
                    if (last_x) begin
                        dx_d = '0;
                        dy_d = dy_q + OW'(1);
                    end else begin
                        dx_d = dx_q + OW'(1);
                    end
                end
            end
        endcase
        state_d = state_t'(state_d);
    end

endmodule

// File: tb/tb_frame_draw_engine.sv
// Directed bench for frame_draw_engine: a reference rasteriser builds the expected
// accepted-pixel sequence and cycle count per frame; a negedge monitor collects DUT pixels.
module tb_frame_draw_engine;

    typedef logic [18:0] pix_t;   // {x[7:0], y[7:0], colour[2:0]}

    logic        CLOCK, RESET, START, clear_en, plot_ready;
    logic [7:0]  paddle_x, paddle_y, ball_x, ball_y;
    logic [19:0] Brick_enable;
    logic [5:0]  brick_color;
    logic [7:0]  x_draw, y_draw;
    logic [2:0]  color;
    logic        enable_plot, busy, complete;

    int   n_total = 0, n_bad = 0;
    int   cyc = 0, comp_cnt = 0, comp_hi = 0, comp_cyc = 0, stall_err = 0, busy_err = 0;
    int   exp_cyc, start_cyc;
    bit   toggle = 0, prev_stall = 0, comp_prev = 0;
    pix_t prev_pix;
    pix_t exp_q[$];
    pix_t got_q[$];

    frame_draw_engine #(
        .SCREEN_W(160), .SCREEN_H(120), .COORD_W(8), .COLOR_W(3),
        .GRID_COLS(10), .GRID_ROWS(2)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .clear_en(clear_en),
        .paddle_x(paddle_x), .paddle_y(paddle_y), .ball_x(ball_x), .ball_y(ball_y),
        .Brick_enable(Brick_enable), .brick_color(brick_color), .plot_ready(plot_ready),
        .x_draw(x_draw), .y_draw(y_draw), .color(color),
        .enable_plot(enable_plot), .busy(busy), .complete(complete)
    );

    initial begin
        CLOCK = 0;
        forever #5 CLOCK = ~CLOCK;
    end

    always @(posedge CLOCK) cyc++;

    // Sink: always ready, or alternating ready/not-ready
    initial begin
        plot_ready = 1'b1;
        forever begin
            @(posedge CLOCK);
            #1 plot_ready = toggle ? ~plot_ready : 1'b1;
        end
    end

    // Monitor: accepted pixels, stall stability, complete pulses
    always @(negedge CLOCK) begin
        if (enable_plot && plot_ready) got_q.push_back({x_draw, y_draw, color});
        if (prev_stall && (!enable_plot || {x_draw, y_draw, color} != prev_pix)) stall_err++;
        prev_stall = enable_plot && !plot_ready;
        prev_pix   = {x_draw, y_draw, color};
        if (complete) begin
            comp_hi++;
            if (!comp_prev) begin
                comp_cnt++;
                comp_cyc = cyc;
            end
            if (busy) busy_err++;
        end
        comp_prev = complete;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add_rect(input int x0, input int y0, input int w, input int h, input int c);
        for (int dy = 0; dy < h; dy++)
            for (int dx = 0; dx < w; dx++) begin
                exp_cyc++;
                if (x0 + dx < 160 && y0 + dy < 120)
                    exp_q.push_back({8'(x0 + dx), 8'(y0 + dy), 3'(c)});
            end
    endtask

    task automatic build_exp(input bit clr, input int px, input int py, input int bx, input int by,
                             input logic [19:0] en, input logic [5:0] bc);
        logic [5:0] b;
        b = bc;
        exp_q.delete();
        exp_cyc = 0;
        if (clr) add_rect(0, 0, 160, 120, 0);
        add_rect(px, py, 16, 2, 7);
        add_rect(bx, by, 2, 2, 7);
        for (int i = 0; i < 20; i++) begin
            if (en[i]) add_rect(35 + (i % 10) * 10, 20 + (i / 10) * 10, 6, 6, int'(b[(i / 10) * 3 +: 3]));
            else exp_cyc++;
        end
    endtask

    task automatic run_frame(input string tag, input bit clr, input int px, input int py,
                             input int bx, input int by, input logic [19:0] en,
                             input logic [5:0] bc, input bit tog, input bit mid);
        int base, base_hi, nmis;
        clear_en = clr; paddle_x = 8'(px); paddle_y = 8'(py); ball_x = 8'(bx); ball_y = 8'(by);
        Brick_enable = en; brick_color = bc;
        build_exp(clr, px, py, bx, by, en, bc);
        @(posedge CLOCK);
        #2;
        toggle = tog;
        got_q.delete();
        stall_err = 0;
        base = comp_cnt;
        base_hi = comp_hi;
        START = 1'b1;
        @(posedge CLOCK);
        #2;
        start_cyc = cyc;
        START = 1'b0;
        for (int i = 0; i < 70000 && comp_cnt == base; i++) begin
            @(negedge CLOCK);
            if (mid && i == 20) begin
                ball_x = 8'd5;
                START = 1'b1;
            end
            if (mid && i == 21) START = 1'b0;
        end
        check({tag, "_done"}, 64'(comp_cnt - base), 64'd1);
        repeat (3) @(negedge CLOCK);
        toggle = 0;
        check({tag, "_cpulse"}, 64'(comp_cnt - base), 64'd1);
        check({tag, "_cwidth"}, 64'(comp_hi - base_hi), 64'd1);
        check({tag, "_npix"}, 64'(got_q.size()), 64'(exp_q.size()));
        nmis = 0;
        foreach (exp_q[k]) if (k >= got_q.size() || got_q[k] !== exp_q[k]) nmis++;
        check({tag, "_seq"}, 64'(nmis), 64'd0);
        if (!tog) check({tag, "_lat"}, 64'(comp_cyc - start_cyc + 1), 64'(exp_cyc + 1));
        else      check({tag, "_stall"}, 64'(stall_err), 64'd0);
    endtask

    initial begin
        int c2, c4, base;
        RESET = 1'b1; START = 1'b0; clear_en = 1'b0;
        paddle_x = '0; paddle_y = '0; ball_x = '0; ball_y = '0;
        Brick_enable = '0; brick_color = '0;
        #23;
        check("rst_out", 64'({x_draw, y_draw, color, busy, complete}), 64'd0);
        check("rst_plot", 64'(enable_plot), 64'd0);
        @(negedge CLOCK);
        RESET = 1'b0;

        // Case 1: full frame with clear, all bricks
        run_frame("full", 1, 70, 110, 80, 60, 20'hFFFFF, 6'b110_011, 0, 0);
        check("full_cnt", 64'(got_q.size()), 64'd19956);
        check("full_first", 64'(got_q[0]), 64'({8'd0, 8'd0, 3'd0}));
        check("full_lastclr", 64'(got_q[19199]), 64'({8'd159, 8'd119, 3'd0}));

        // Case 2: one brick, no clear
        run_frame("one", 0, 70, 110, 80, 60, 20'h00001, 6'b011_101, 0, 0);
        check("one_cnt", 64'(got_q.size()), 64'd72);
        check("one_cyc", 64'(comp_cyc - start_cyc + 1), 64'd92);
        check("one_bfirst", 64'(got_q[36]), 64'({8'd35, 8'd20, 3'd5}));
        check("one_blast", 64'(got_q[71]), 64'({8'd40, 8'd25, 3'd5}));

        // Case 3: back-pressure
        run_frame("bp", 1, 70, 110, 80, 60, 20'hFFFFF, 6'b110_011, 1, 0);

        // Case 4: clipping at right edge, ball beyond 8-bit edge
        run_frame("clip", 0, 150, 100, 255, 50, 20'h00000, 6'b000_000, 0, 0);
        check("clip_cnt", 64'(got_q.size()), 64'd20);
        check("clip_first", 64'(got_q[0]), 64'({8'd150, 8'd100, 3'd7}));
        check("clip_last", 64'(got_q[19]), 64'({8'd159, 8'd101, 3'd7}));

        // Case 5: per-row colours, mid-frame input changes ignored
        run_frame("rowc", 0, 70, 110, 80, 60, 20'h00401, 6'b100_010, 0, 1);
        c2 = 0; c4 = 0;
        foreach (got_q[k]) begin
            if (got_q[k][2:0] == 3'd2) c2++;
            if (got_q[k][2:0] == 3'd4) c4++;
        end
        check("rowc_c2", 64'(c2), 64'd36);
        check("rowc_c4", 64'(c4), 64'd36);
        check("rowc_ball", 64'(got_q[32]), 64'({8'd80, 8'd60, 3'd7}));

        // Case 6: asynchronous abort mid-clear, then redraw
        clear_en = 1'b1;
        @(posedge CLOCK);
        #2 START = 1'b1;
        @(posedge CLOCK);
        #2 START = 1'b0;
        for (int i = 0; i < 2000 && got_q.size() < 500; i++) @(negedge CLOCK);
        #2;
        check("abort_busy", 64'(busy), 64'd1);
        base = comp_cnt;
        RESET = 1'b1;
        #1;
        check("abort_plot", 64'(enable_plot), 64'd0);
        check("abort_busy0", 64'(busy), 64'd0);
        check("abort_xy", 64'({x_draw, y_draw}), 64'd0);
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK);
        check("abort_nocomp", 64'(comp_cnt - base), 64'd0);
        run_frame("redraw", 1, 70, 110, 80, 60, 20'hFFFFF, 6'b110_011, 0, 0);
        check("redraw_first", 64'(got_q[0]), 64'({8'd0, 8'd0, 3'd0}));

        check("busy_in_done", 64'(busy_err), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
